line_endpoint_capture: RTL

- Producer side of the line-drawing interface. Turns a per-frame tracked-marker centroid plus a user button into a committed line segment.
- Outputs two endpoint pairs and a one-cycle place_obj strobe for the line renderer.
- Drives live preview endpoints while the user drags the second point.
- Sits between the centroid/tracking stage and the renderer, in the pixel clock domain.

---
 rtl/line_pkg.sv | 24 ++
 rtl/point_averager.sv | 63 ++++++
 rtl/line_endpoint_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/line_pkg.sv
// Shared types and helpers for the line-endpoint capture path.
`timescale 1ns/1ps
package line_pkg;

  typedef logic [10:0] coord_x_t;
  typedef logic [9:0]  coord_y_t;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE_P1,
    WAIT_P2,
    SAMPLE_P2,
    CHECK,
    PLACE
  } capture_state_t;

  localparam int AVG_FRAMES_DEF = 4;
  localparam int AVG_SHIFT      = $clog2(AVG_FRAMES_DEF);

  function automatic int avg_shift(input int frames);
    return $clog2(frames);
  endfunction

endpackage

// File: rtl/point_averager.sv
// Accumulates AVG_FRAMES centroid samples and presents their truncated mean.
`timescale 1ns/1ps
module point_averager
  import line_pkg::*;
#(
  parameter int AVG_FRAMES = AVG_FRAMES_DEF
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     clear_in,
  input  logic     sample_in,
  input  coord_x_t x_in,
  input  coord_y_t y_in,
  output logic     done_out,
  output coord_x_t avg_x_out,
  output coord_y_t avg_y_out
);

  localparam int         SHIFT = avg_shift(AVG_FRAMES);
  localparam logic [4:0] LAST  = 5'(AVG_FRAMES - 1);

  logic [14:0] acc_x_q, acc_x_d;
  logic [13:0] acc_y_q, acc_y_d;
  logic [4:0]  count_q, count_d;
  logic        done_q, done_d;

  // Samples beyond the last one are ignored until the next clear.
  always_comb begin
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (clear_in) begin
      acc_x_d = '0;
      acc_y_d = '0;
      count_d = '0;
    end else if (sample_in && (count_q <= LAST)) begin
      acc_x_d = acc_x_q + 15'(x_in);
      acc_y_d = acc_y_q + 14'(y_in);
      count_d = count_q + 5'd1;
      done_d  = (count_q == LAST);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_x_q <= '0;
      acc_y_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done_out  = done_q;
  assign avg_x_out = acc_x_q[SHIFT +: 11];
  assign avg_y_out = acc_y_q[SHIFT +: 10];

endmodule

// File: rtl/line_endpoint_capture.sv
// Turns averaged marker centroids plus button presses into a committed line segment.
// Optional endpoint snapping is enabled with the LINE_SNAP_EN macro.
`timescale 1ns/1ps
module line_endpoint_capture
  import line_pkg::*;
#(
  parameter int AVG_FRAMES = 4,
  parameter int MIN_LEN    = 8,
  parameter int SNAP_TOL   = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] centroid_x_in,
  input  logic [9:0]  centroid_y_in,
  input  logic        centroid_valid_in,
  input  logic        button_in,
  input  logic        cancel_in,
  output logic [10:0] x_out_1,
  output logic [9:0]  y_out_1,
  output logic [10:0] x_out_2,
  output logic [9:0]  y_out_2,
  output logic        preview_out,
  output logic        place_obj,
  output logic        reject_out,
  output logic        busy_out
);

  capture_state_t state_q, state_d;
  coord_x_t x1_q, x1_d, x2_q, x2_d, avg_x;
  coord_y_t y1_q, y1_d, y2_q, y2_d, avg_y;
  logic button_q, button_d, armed_q, armed_d;
  logic preview_q, preview_d, place_q, place_d, reject_q, reject_d, busy_q, busy_d;
  logic rise, avg_clear, avg_sample, avg_done;
  logic [11:0] adx, ady;
  logic [12:0] len;

  point_averager #(.AVG_FRAMES(AVG_FRAMES)) u_avg (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (avg_clear),
    .sample_in (avg_sample),
    .x_in      (centroid_x_in),
    .y_in      (centroid_y_in),
    .done_out  (avg_done),
    .avg_x_out (avg_x),
    .avg_y_out (avg_y)
  );

  // A button already held through reset must be seen low once before it can act.
  assign rise = button_in & ~button_q & armed_q;

  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x2_d       = x2_q;
    y2_d       = y2_q;
    button_d   = button_in;
    armed_d    = armed_q | ~button_in;
    place_d    = 1'b0;
    reject_d   = 1'b0;
    avg_clear  = 1'b0;
    avg_sample = 1'b0;
    adx = (x2_q >= x1_q) ? 12'(x2_q - x1_q) : 12'(x1_q - x2_q);
    ady = (y2_q >= y1_q) ? 12'(y2_q - y1_q) : 12'(y1_q - y2_q);
    len = 13'(adx) + 13'(ady);
    if ((state_q != IDLE) && cancel_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d   = SAMPLE_P1;
          avg_clear = 1'b1;
        end
        SAMPLE_P1: begin
          avg_sample = centroid_valid_in;
          if (avg_done) begin
            x1_d    = avg_x;
            y1_d    = avg_y;
            state_d = WAIT_P2;
          end
        end
        WAIT_P2: begin
          if (centroid_valid_in) begin
            x2_d = centroid_x_in;
            y2_d = centroid_y_in;
          end
          if (rise) begin
            state_d   = SAMPLE_P2;
            avg_clear = 1'b1;
          end
        end
        SAMPLE_P2: begin
          avg_sample = centroid_valid_in;
          if (avg_done) begin
            x2_d    = avg_x;
            y2_d    = avg_y;
            state_d = CHECK;
          end
        end
        CHECK: begin
`ifdef LINE_SNAP_EN
          // A snapped axis contributes nothing to the length test.
          if (ady <= 12'(SNAP_TOL)) begin
            y2_d = y1_q;
            len  = 13'(adx);
          end else if (adx <= 12'(SNAP_TOL)) begin
            x2_d = x1_q;
            len  = 13'(ady);
          end
`endif
          if (len < 13'(MIN_LEN)) begin
            reject_d = 1'b1;
            state_d  = IDLE;
          end else begin
            place_d = 1'b1;
            state_d = PLACE;
          end
        end
        PLACE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    preview_d = (state_d == WAIT_P2) || (state_d == SAMPLE_P2);
    busy_d    = (state_d != IDLE);
  end

`ifndef LINE_SNAP_EN
  logic unused_snap_tol;
  assign unused_snap_tol = ^12'(SNAP_TOL);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      button_q  <= 1'b0;
      armed_q   <= 1'b0;
      preview_q <= 1'b0;
      place_q   <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      button_q  <= button_d;
      armed_q   <= armed_d;
      preview_q <= preview_d;
      place_q   <= place_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
    end
  end

  assign x_out_1     = x1_q;
  assign y_out_1     = y1_q;
  assign x_out_2     = x2_q;
  assign y_out_2     = y2_q;
  assign preview_out = preview_q;
  assign place_obj   = place_q;
  assign reject_out  = reject_q;
  assign busy_out    = busy_q;

endmodule
